gray_code_conv: RTL and testbench
=================================

GRAY_CODE_CONV -- requirements
Module: gray_code_conv

Interface
REQ-001 Parameter WIDTH, default 4: code word width in bits; legal range 2..64.
REQ-002 Parameter CNT_W, default 16: width of the completed-transfer counter.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous and active-low.
REQ-005 Port in_valid  input  1: input word present.
REQ-006 Port in_ready  output  1: block accepts the input word this cycle.
REQ-007 Port in_mode  input  1: 0 = binary-to-Gray, 1 = Gray-to-binary; sampled with in_data.
REQ-008 Port in_data  input  WIDTH: word to convert.
REQ-009 Port out_valid  output  1: converted word present.
REQ-010 Port out_ready  input  1: downstream accepts the output word.
REQ-011 Port out_data  output  WIDTH: converted word.
REQ-012 Port out_mode  output  1: mode the out_data word was converted with.
REQ-013 Port xfer_cnt  output  CNT_W: count of completed output transfers.
REQ-014 Port step_err  output  1: Gray step-check flag; present only with GRAY_CONV_STEP_CHK_EN.

Function
REQ-015 Transfer rule: input accepted when in_valid && in_ready; output completes when out_valid && out_ready.
REQ-016 Two-stage pipeline: stage 1 registers in_data/in_mode/valid; stage 2 registers the conversion result/mode/valid.
REQ-017 Global advance = !out_valid || out_ready; in_ready SHALL equal advance; both stages load only when advance is 1.
REQ-018 Latency 2 cycles from acceptance to out_valid without stall; throughput one word per cycle when out_ready is held 1.
REQ-019 Bubbles propagate: stage 1 with valid 0 SHALL load stage 2 valid 0 on advance.
REQ-020 Binary-to-Gray: out[WIDTH-1] = in[WIDTH-1]; out[i] = in[i+1] XOR in[i] for i < WIDTH-1.
REQ-021 Gray-to-binary: out[WIDTH-1] = in[WIDTH-1]; out[i] = out[i+1] XOR in[i] (prefix XOR from MSB down).
REQ-022 While out_valid && !out_ready, out_data, out_mode and out_valid SHALL hold stable.
REQ-023 Mode may change on every accepted word; each word is converted with its own sampled mode.
REQ-024 xfer_cnt SHALL increment by 1 on each completed output transfer and wrap from all-ones to 0.

Reset
REQ-025 When rst_n is 0 at a rising edge: both stage valids, out_data, out_mode, xfer_cnt and step_err SHALL become 0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset release.
REQ-027 Reset mid-operation SHALL discard all in-flight words without producing an output transfer.

Configuration
REQ-028 Macro GRAY_CONV_STEP_CHK_EN defined: block tracks the last accepted mode-1 (Gray) input word and a history-valid bit.
REQ-029 With the macro: on acceptance of a mode-1 word whose Hamming distance to the tracked word is not exactly 1 while history is valid, step_err SHALL be set one cycle later and remain set (sticky) until reset.
REQ-030 With the macro: the first mode-1 word after reset only loads history; mode-0 words do not affect history or step_err.
REQ-031 Without the macro: step_err port, history register and compare logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Shared package gray_conv_pkg SHALL hold the mode constants (MODE_B2G = 0, MODE_G2B = 1) and the default WIDTH/CNT_W values.
REQ-033 Conversion SHALL reside in combinational sub-module gray_conv_core (ports: mode, din, dout; parameter WIDTH), instantiated between stage 1 and stage 2.

Verification
REQ-034 WIDTH=4, mode 0, in_data 4'b1011, out_ready 1 -> out_data 4'b1110, out_mode 0, out_valid exactly 2 cycles after acceptance.
REQ-035 WIDTH=8, back-to-back words: mode 0 8'hFF, then mode 1 8'h80 -> out_data 8'h80 then 8'hFF on consecutive cycles; xfer_cnt 0 -> 2.
REQ-036 Backpressure: out_ready 0 for 5 cycles with pipeline full -> in_ready 0 and out_data held stable; on release, words emerge in order, none lost or duplicated.
REQ-037 Reset asserted with 2 words in flight -> next cycle out_valid 0, xfer_cnt 0, in_ready 1; no output transfer of discarded words.
REQ-038 CNT_W=4, 17 completed transfers -> xfer_cnt wraps to 4'h1.
REQ-039 GRAY_CONV_STEP_CHK_EN defined, WIDTH=4, mode-1 inputs 4'b0000, 4'b0001, 4'b0010 -> step_err 0 after the second word, 1 after the third, stays 1 until rst_n 0.

Source files
------------

// File: rtl/gray_conv_pkg.sv
// rtl/gray_conv_pkg.sv - shared constants and helpers for the Gray code converter
package gray_conv_pkg;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    // True when exactly one bit is set: a legal single Gray step between two words.
    function automatic logic is_unit_step(input logic [63:0] diff);
        return (diff != 64'd0) && ((diff & (diff - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/gray_conv_core.sv
// rtl/gray_conv_core.sv - combinational binary<->Gray conversion selected by mode
module gray_conv_core
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] b2g;
    logic [WIDTH-1:0] g2b;

    // Gray-to-binary bit i is the XOR of all input bits from i up to the MSB.
    always_comb begin
        b2g = din ^ (din >> 1);
        g2b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            g2b[i] = ^(din >> i);
        end
        dout = (mode == MODE_G2B) ? g2b : b2g;
    end

endmodule

// File: rtl/gray_code_conv.sv
// rtl/gray_code_conv.sv - two-stage Gray converter pipeline; GRAY_CONV_STEP_CHK_EN adds the Gray step checker
module gray_code_conv
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic [CNT_W-1:0] xfer_cnt
`ifdef GRAY_CONV_STEP_CHK_EN
    ,
    output logic             step_err
`endif
);

    logic             advance;
    logic             accept;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_mode_q,  s1_mode_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_mode_q,  s2_mode_d;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] conv_data;

    // Both stages move together; a held output freezes the whole pipe.
    assign advance = !s2_valid_q || out_ready;
    assign accept  = in_valid && advance;

    gray_conv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .mode (s1_mode_q),
        .din  (s1_data_q),
        .dout (conv_data)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_mode_d  = s2_mode_q;
        s2_data_d  = s2_data_q;
        cnt_d      = cnt_q;
        if (advance) begin
            s1_valid_d = in_valid;
            s1_mode_d  = in_mode;
            s1_data_d  = in_data;
            s2_valid_d = s1_valid_q;
            s2_mode_d  = s1_mode_q;
            s2_data_d  = conv_data;
        end
        if (s2_valid_q && out_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_mode_q  <= s2_mode_d;
            s2_data_q  <= s2_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = s2_valid_q;
    assign out_mode  = s2_mode_q;
    assign out_data  = s2_data_q;
    assign xfer_cnt  = cnt_q;

`ifdef GRAY_CONV_STEP_CHK_EN
    logic [WIDTH-1:0] hist_q, hist_d;
    logic             hist_valid_q, hist_valid_d;
    logic             step_err_q, step_err_d;

    // Only accepted Gray-mode words feed the history; the error is sticky until reset.
    always_comb begin
        hist_d       = hist_q;
        hist_valid_d = hist_valid_q;
        step_err_d   = step_err_q;
        if (accept && (in_mode == MODE_G2B)) begin
            if (hist_valid_q && !is_unit_step(64'(hist_q ^ in_data))) begin
                step_err_d = 1'b1;
            end
            hist_d       = in_data;
            hist_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q       <= '0;
            hist_valid_q <= 1'b0;
            step_err_q   <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            hist_valid_q <= hist_valid_d;
            step_err_q   <= step_err_d;
        end
    end

    assign step_err = step_err_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gray_code_conv.sv
// tb/tb_gray_code_conv.sv - directed self-checking bench for gray_code_conv
module tb_gray_code_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic       a_rst_n, a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
    logic [7:0] a_in_data, a_out_data;
    logic [15:0] a_xfer_cnt;

    logic       b_rst_n, b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
    logic [3:0] b_in_data, b_out_data;
    logic [3:0] b_xfer_cnt;

`ifdef GRAY_CONV_STEP_CHK_EN
    logic a_step_err, b_step_err;
`endif

    gray_code_conv #(.WIDTH(8), .CNT_W(16)) dut_a (
        .clk       (clk),
        .rst_n     (a_rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_mode   (a_in_mode),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_mode  (a_out_mode),
        .xfer_cnt  (a_xfer_cnt)
`ifdef GRAY_CONV_STEP_CHK_EN
        ,
        .step_err  (a_step_err)
`endif
    );

    gray_code_conv #(.WIDTH(4), .CNT_W(4)) dut_b (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_mode   (b_in_mode),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_mode  (b_out_mode),
        .xfer_cnt  (b_xfer_cnt)
`ifdef GRAY_CONV_STEP_CHK_EN
        ,
        .step_err  (b_step_err)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_mode = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        tick();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_a_out_valid: got %b want 0", a_out_valid); end
        tests_run++; if (a_out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_a_out_data: got %h want 00", a_out_data); end
        tests_run++; if (a_out_mode !== 1'b0) begin tests_failed++; $display("FAIL reset_a_out_mode: got %b want 0", a_out_mode); end
        tests_run++; if (a_xfer_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_a_xfer_cnt: got %0d want 0", a_xfer_cnt); end
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_a_in_ready: got %b want 1", a_in_ready); end
        tests_run++; if (b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); end
        tests_run++; if (b_xfer_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_b_xfer_cnt: got %0d want 0", b_xfer_cnt); end
        tests_run++; if (b_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_b_in_ready: got %b want 1", b_in_ready); end
`ifdef GRAY_CONV_STEP_CHK_EN
        tests_run++; if (b_step_err !== 1'b0) begin tests_failed++; $display("FAIL reset_b_step_err: got %b want 0", b_step_err); end
`endif
    endtask

    task automatic test_latency;
        do_reset();
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_data = 4'b1011;
        tick();
        b_in_valid = 1'b1; b_in_mode = 1'b1; b_in_data = 4'b1011;
        tests_run++; if (b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_out_valid_c1: got %b want 0", b_out_valid); end
        tick();
        b_in_valid = 1'b0;
        tests_run++; if (b_out_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_out_valid_c2: got %b want 1", b_out_valid); end
        tests_run++; if (b_out_data !== 4'b1110) begin tests_failed++; $display("FAIL lat_b2g_data: got %b want 1110", b_out_data); end
        tests_run++; if (b_out_mode !== 1'b0) begin tests_failed++; $display("FAIL lat_b2g_mode: got %b want 0", b_out_mode); end
        tick();
        tests_run++; if (b_out_data !== 4'b1101) begin tests_failed++; $display("FAIL lat_g2b_data: got %b want 1101", b_out_data); end
        tests_run++; if (b_out_mode !== 1'b1) begin tests_failed++; $display("FAIL lat_g2b_mode: got %b want 1", b_out_mode); end
        tick();
        tests_run++; if (b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_bubble: got %b want 0", b_out_valid); end
        tests_run++; if (b_xfer_cnt !== 4'd2) begin tests_failed++; $display("FAIL lat_xfer_cnt: got %0d want 2", b_xfer_cnt); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 8'hFF;
        tick();
        a_in_valid = 1'b1; a_in_mode = 1'b1; a_in_data = 8'h80;
        tick();
        a_in_valid = 1'b0;
        tests_run++; if (a_out_data !== 8'h80 || a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_word0: got v=%b %h want v=1 80", a_out_valid, a_out_data); end
        tests_run++; if (a_xfer_cnt !== 16'd0) begin tests_failed++; $display("FAIL b2b_cnt0: got %0d want 0", a_xfer_cnt); end
        tick();
        tests_run++; if (a_out_data !== 8'hFF || a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_word1: got v=%b %h want v=1 FF", a_out_valid, a_out_data); end
        tests_run++; if (a_out_mode !== 1'b1) begin tests_failed++; $display("FAIL b2b_mode1: got %b want 1", a_out_mode); end
        tick();
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drained: got %b want 0", a_out_valid); end
        tests_run++; if (a_xfer_cnt !== 16'd2) begin tests_failed++; $display("FAIL b2b_cnt2: got %0d want 2", a_xfer_cnt); end
    endtask

    task automatic test_backpressure;
        logic [7:0] want [3];
        want[0] = 8'h08; want[1] = 8'h2A; want[2] = 8'hFF;
        do_reset();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 8'h0F;
        tick();
        a_in_data = 8'h33;
        tick();
        a_in_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready_c%0d: got %b want 0", i, a_in_ready); end
            tests_run++; if (a_out_valid !== 1'b1 || a_out_data !== want[0]) begin tests_failed++; $display("FAIL bp_hold_c%0d: got v=%b %h want v=1 %h", i, a_out_valid, a_out_data, want[0]); end
            tick();
        end
        tests_run++; if (a_xfer_cnt !== 16'd0) begin tests_failed++; $display("FAIL bp_cnt_stalled: got %0d want 0", a_xfer_cnt); end
        a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            tests_run++; if (a_out_valid !== 1'b1 || a_out_data !== want[i]) begin tests_failed++; $display("FAIL bp_order_w%0d: got v=%b %h want v=1 %h", i, a_out_valid, a_out_data, want[i]); end
            tick();
        end
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_no_dup: got %b want 0", a_out_valid); end
        tests_run++; if (a_xfer_cnt !== 16'd3) begin tests_failed++; $display("FAIL bp_cnt: got %0d want 3", a_xfer_cnt); end
    endtask

    task automatic test_reset_inflight;
        do_reset();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 8'h12;
        tick();
        a_in_data = 8'h34;
        tick();
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_rst_n = 1'b0;
        tick();
        a_rst_n = 1'b1;
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL rif_out_valid: got %b want 0", a_out_valid); end
        tests_run++; if (a_xfer_cnt !== 16'd0) begin tests_failed++; $display("FAIL rif_xfer_cnt: got %0d want 0", a_xfer_cnt); end
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL rif_in_ready: got %b want 1", a_in_ready); end
        tick();
        tick();
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL rif_discarded: got %b want 0", a_out_valid); end
        tests_run++; if (a_xfer_cnt !== 16'd0) begin tests_failed++; $display("FAIL rif_cnt_after: got %0d want 0", a_xfer_cnt); end
    endtask

    task automatic test_cnt_wrap;
        do_reset();
        b_out_ready = 1'b1;
        b_in_mode = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b_in_valid = 1'b1;
            b_in_data = 4'(i);
            tick();
        end
        b_in_valid = 1'b0;
        tick();
        tick();
        tests_run++; if (b_xfer_cnt !== 4'h1) begin tests_failed++; $display("FAIL wrap_cnt: got %h want 1", b_xfer_cnt); end
        tests_run++; if (b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_drained: got %b want 0", b_out_valid); end
    endtask

`ifdef GRAY_CONV_STEP_CHK_EN
    task automatic test_step_chk;
        do_reset();
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_mode = 1'b1; b_in_data = 4'b0000;
        tick();
        b_in_data = 4'b0001;
        tick();
        b_in_mode = 1'b0; b_in_data = 4'b1111;
        tests_run++; if (b_step_err !== 1'b0) begin tests_failed++; $display("FAIL step_ok: got %b want 0", b_step_err); end
        tick();
        b_in_mode = 1'b1; b_in_data = 4'b0010;
        tests_run++; if (b_step_err !== 1'b0) begin tests_failed++; $display("FAIL step_mode0_ignored: got %b want 0", b_step_err); end
        tick();
        b_in_valid = 1'b0;
        tests_run++; if (b_step_err !== 1'b1) begin tests_failed++; $display("FAIL step_err_set: got %b want 1", b_step_err); end
        tick();
        tick();
        tests_run++; if (b_step_err !== 1'b1) begin tests_failed++; $display("FAIL step_err_sticky: got %b want 1", b_step_err); end
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        tests_run++; if (b_step_err !== 1'b0) begin tests_failed++; $display("FAIL step_err_cleared: got %b want 0", b_step_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        test_cnt_wrap();
`ifdef GRAY_CONV_STEP_CHK_EN
        test_step_chk();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
